// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encodings,
// reset-cause bit positions and a small sizing helper.
package rst_seq_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_ASSERT  = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  // Bit positions inside the sticky reset-cause vector {sw, async, por}
  localparam int CAUSE_POR   = 0;
  localparam int CAUSE_ASYNC = 1;
  localparam int CAUSE_SW    = 2;

  // Larger of two integers, used to size the shared down-counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sync_cell.sv
// Multi-flop synchroniser for a single asynchronous level.
// The whole chain is cleared synchronously by clr_i.
module rst_sync_cell #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  // Shift the raw input through the chain; bit 0 is the metastability-catching flop
  always_ff @(posedge clk) begin
    if (clr_i) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: synchronises an asynchronous reset request, merges it
// with a software request, holds all outputs asserted for STRETCH cycles
// after the last request and then releases them one by one in ascending
// index order, GAP cycles apart.
// Optional feature macro: RST_SEQ_CAUSE_EN adds cause_clr / rst_cause,
// a sticky record of which sources caused a reset.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH     = 8,
  parameter int GAP         = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            async_rst,
  input  logic            sw_rst_req,
`ifdef RST_SEQ_CAUSE_EN
  input  logic            cause_clr,
  output logic [2:0]      rst_cause,
`endif
  output logic [N_CH-1:0] rst_out,
  output logic            all_released,
  output logic            busy
);

  localparam int CW  = $clog2(max_int(STRETCH, GAP) + 1);
  localparam int CHW = $clog2(N_CH) + 1;

  localparam logic [CW-1:0]  STRETCH_C = CW'(STRETCH);
  localparam logic [CW-1:0]  GAP_C     = CW'(GAP);
  localparam logic [CW-1:0]  ONE_C     = CW'(1);
  localparam logic [CHW-1:0] LAST_CH   = CHW'(N_CH - 1);

  logic            a_sync;
  logic            req;
  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CHW-1:0]  ch_q, ch_d;
  logic [N_CH-1:0] rst_out_q, rst_out_d;
  logic [N_CH-1:0] rel_mask;

  rst_sync_cell #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .clr_i (rst),
    .d_i   (async_rst),
    .q_o   (a_sync)
  );

  assign req = a_sync | sw_rst_req;

  // One-hot mask selecting the channel currently due for release
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_mask
      assign rel_mask[gi] = (ch_q == CHW'(gi));
    end
  endgenerate

  // Next-state logic: any request aborts to ASSERT with a full stretch reload
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    rst_out_d = rst_out_q;
    if (req) begin
      state_d   = ST_ASSERT;
      cnt_d     = STRETCH_C;
      ch_d      = '0;
      rst_out_d = '1;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          rst_out_d = '1;
          if (cnt_q == ONE_C) begin
            if (N_CH == 1) begin
              state_d   = ST_RUN;
              rst_out_d = '0;
            end else begin
              state_d      = ST_RELEASE;
              rst_out_d[0] = 1'b0;
              ch_d         = CHW'(1);
              cnt_d        = GAP_C;
            end
          end else begin
            cnt_d = cnt_q - ONE_C;
          end
        end
        ST_RELEASE: begin
          if (cnt_q == ONE_C) begin
            rst_out_d = rst_out_q & ~rel_mask;
            if (ch_q == LAST_CH) begin
              state_d = ST_RUN;
            end else begin
              ch_d  = ch_q + CHW'(1);
              cnt_d = GAP_C;
            end
          end else begin
            cnt_d = cnt_q - ONE_C;
          end
        end
        ST_RUN: begin
          rst_out_d = '0;
        end
        default: begin
          state_d   = ST_ASSERT;
          cnt_d     = STRETCH_C;
          ch_d      = '0;
          rst_out_d = '1;
        end
      endcase
    end
  end

  // State, counters and output register; block reset forces full assertion
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ASSERT;
      cnt_q     <= STRETCH_C;
      ch_q      <= '0;
      rst_out_q <= '1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      rst_out_q <= rst_out_d;
    end
  end

  assign rst_out      = rst_out_q;
  assign all_released = ~|rst_out_q;
  assign busy         = |rst_out_q;

`ifdef RST_SEQ_CAUSE_EN
  logic       a_sync_q;
  logic [2:0] cause_q, cause_d;

  // Sticky cause bits: a clear pulse wipes them, but a new event in the same cycle wins
  always_comb begin
    cause_d = cause_q;
    if (cause_clr) begin
      cause_d = '0;
    end
    if (sw_rst_req) begin
      cause_d[CAUSE_SW] = 1'b1;
    end
    if (a_sync && !a_sync_q) begin
      cause_d[CAUSE_ASYNC] = 1'b1;
    end
  end

  // Cause register and synchronised-request edge detector
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sync_q <= 1'b0;
      cause_q  <= 3'(1 << CAUSE_POR);
    end else begin
      a_sync_q <= a_sync;
      cause_q  <= cause_d;
    end
  end

  assign rst_cause = cause_q;
`endif

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer (defaults N_CH=4, STRETCH=8, GAP=4, SYNC_STAGES=2).
// Table of synchronous-request vectors with expected outputs derived from
// the release timeline, plus hand sequences for the async path and, when
// RST_SEQ_CAUSE_EN is defined, the cause register.
module tb_rst_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       async_rst = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic [3:0] rst_out;
  logic       all_released;
  logic       busy;
`ifdef RST_SEQ_CAUSE_EN
  logic       cause_clr = 1'b0;
  logic [2:0] rst_cause;
`endif

  rst_sequencer #(
    .N_CH        (4),
    .SYNC_STAGES (2),
    .STRETCH     (8),
    .GAP         (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .async_rst    (async_rst),
    .sw_rst_req   (sw_rst_req),
`ifdef RST_SEQ_CAUSE_EN
    .cause_clr    (cause_clr),
    .rst_cause    (rst_cause),
`endif
    .rst_out      (rst_out),
    .all_released (all_released),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       s;
    logic [3:0] exp_out;
  } vec_t;

  typedef struct {
    int         idx;
    logic [3:0] exp_out;
    logic       exp_all;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   since    = 0;

  // Expected rst_out k edges after the last edge that saw a request
  function automatic logic [3:0] release_pattern(input int k);
    if (k < 8)       return 4'hF;
    else if (k < 12) return 4'hE;
    else if (k < 16) return 4'hC;
    else if (k < 20) return 4'h8;
    else             return 4'h0;
  endfunction

  // One vector with the given request inputs, followed by idle vectors
  task automatic add(input logic r, input logic s, input int idle);
    vec_t v;
    since     = 0;
    v.r       = r;
    v.s       = s;
    v.exp_out = release_pattern(0);
    vecs.push_back(v);
    for (int i = 0; i < idle; i++) begin
      if (since < 1000) since++;
      v.r       = 1'b0;
      v.s       = 1'b0;
      v.exp_out = release_pattern(since);
      vecs.push_back(v);
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   got_edge;

    // Power-on reset for 3 cycles, full release into RUN
    add(1'b1, 1'b0, 0);
    add(1'b1, 1'b0, 0);
    add(1'b1, 1'b0, 24);
    // Software request while running
    add(1'b0, 1'b1, 24);
    // Software request in RELEASE once rst_out has reached 4'hC (abort)
    add(1'b0, 1'b1, 13);
    add(1'b0, 1'b1, 24);
    // Software request every 5 cycles keeps everything asserted
    add(1'b0, 1'b1, 4);
    add(1'b0, 1'b1, 4);
    add(1'b0, 1'b1, 4);
    add(1'b0, 1'b1, 24);
    // Request right after channel 0 released
    add(1'b0, 1'b1, 9);
    add(1'b0, 1'b1, 24);
    // Block reset together with a software request behaves as reset
    add(1'b1, 1'b1, 24);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst        = vecs[i].r;
      sw_rst_req = vecs[i].s;
      e.idx      = i;
      e.exp_out  = vecs[i].exp_out;
      e.exp_all  = (vecs[i].exp_out == 4'h0);
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      $display("vec %0d rst=%0b sw=%0b rst_out=%h exp=%h", e.idx, vecs[i].r, vecs[i].s, rst_out, e.exp_out);
      check("rst_out", 32'(rst_out), 32'(e.exp_out));
      check("all_released", 32'(all_released), 32'(e.exp_all));
      check("busy", 32'(busy), 32'(!e.exp_all));
    end
    @(negedge clk);
    rst        = 1'b0;
    sw_rst_req = 1'b0;

    // Async request raised mid-cycle for 3 clocks while in RUN
    @(posedge clk);
    #2 async_rst = 1'b1;
    got_edge = 0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      if (rst_out == 4'hF && got_edge == 0) got_edge = i;
    end
    $display("async: rst_out asserted after edge %0d", got_edge);
    check("async_latency", 32'(got_edge != 0), 32'd1);
    #1 async_rst = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    $display("async: hold end rst_out=%h", rst_out);
    check("async_hold", 32'(rst_out), 32'hF);
    @(posedge clk);
    #1;
    $display("async: first release rst_out=%h", rst_out);
    check("async_rel0", 32'(rst_out), 32'hE);
    repeat (12) @(posedge clk);
    #1;
    $display("async: final rst_out=%h all_released=%0b", rst_out, all_released);
    check("async_done", 32'(rst_out), 32'h0);
    check("async_all_rel", 32'(all_released), 32'd1);

`ifdef RST_SEQ_CAUSE_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("cause: after por %b", rst_cause);
    check("cause_por", 32'(rst_cause), 32'b001);
    async_rst = 1'b1;
    repeat (2) @(negedge clk);
    async_rst = 1'b0;
    repeat (4) @(negedge clk);
    $display("cause: after async %b", rst_cause);
    check("cause_async", 32'(rst_cause), 32'b011);
    sw_rst_req = 1'b1;
    @(negedge clk);
    sw_rst_req = 1'b0;
    $display("cause: after sw %b", rst_cause);
    check("cause_sw", 32'(rst_cause), 32'b111);
    cause_clr = 1'b1;
    @(negedge clk);
    cause_clr = 1'b0;
    $display("cause: after clear %b", rst_cause);
    check("cause_clr", 32'(rst_cause), 32'b000);
    cause_clr  = 1'b1;
    sw_rst_req = 1'b1;
    @(negedge clk);
    cause_clr  = 1'b0;
    sw_rst_req = 1'b0;
    $display("cause: clear with sw %b", rst_cause);
    check("cause_set_wins", 32'(rst_cause), 32'b100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
